// File: rtl/aes_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES definitions for the decrypt datapath: FSM state
//            encoding, block/key-index widths, GF(2^8) helpers, the inverse
//            S-box and the legal round-count check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int RK_IDX_W    = 4;

   typedef enum logic [1:0] {
      INV_IDLE  = 2'd0,
      INV_ROUND = 2'd1,
      INV_FINAL = 2'd2,
      INV_DONE  = 2'd3
   } inv_fsm_e;

   // Only the three standard AES key sizes are supported.
   function automatic logic nr_legal(input int nr);
      return (nr == 10) || (nr == 12) || (nr == 14);
   endfunction

   // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = gf_xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (addition chain 1,3,7,15,...,127,254);
   // zero maps to zero as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < 6; i++) begin
         r = gf_mul(r, r);
         r = gf_mul(r, a);
      end
      return gf_mul(r, r);
   endfunction

   // Inverse S-box: undo the affine transform, then invert in GF(2^8).
   // Bit i of the inverse affine takes bits i+2, i+5, i+7, i.e. left
   // rotations by 6, 3 and 1, plus the constant 0x05.
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] t;
      t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(t);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher_if
// Purpose  : Block handshake and key-store lookup bundle of the inverse
//            cipher engine.
// Ports    : in_valid/in_ready/in_block  - ciphertext input handshake
//            rk_idx/rk                    - round-key lookup (combinational)
//            out_valid/out_ready/out_block- plaintext output handshake
//            busy                         - engine occupied
//            modport slave  : engine side
//            modport master : environment side (FIFO, key store, sink)
// Revision : 1.0 - initial release
// ============================================================================
interface aes_inv_cipher_if;
   import aes_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [AES_BLOCK_W-1:0] in_block;
   logic [RK_IDX_W-1:0]    rk_idx;
   logic [AES_BLOCK_W-1:0] rk;
   logic                   out_valid;
   logic                   out_ready;
   logic [AES_BLOCK_W-1:0] out_block;
   logic                   busy;

   modport slave (
      input  in_valid, in_block, rk, out_ready,
      output in_ready, rk_idx, out_valid, out_block, busy
   );

   modport master (
      output in_valid, in_block, rk, out_ready,
      input  in_ready, rk_idx, out_valid, out_block, busy
   );

endinterface
`default_nettype wire

// File: rtl/aes_inv_round.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_inv_round
// Purpose  : Combinational AES inverse round:
//            InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns,
//            with InvMixColumns bypassed for the last round.
// Ports    : state_in  [127:0] - current state (column-major)
//            rk        [127:0] - round key
//            last              - 1: skip InvMixColumns
//            state_out [127:0] - next state
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] state_in,
   input  logic [AES_BLOCK_W-1:0] rk,
   input  logic                   last,
   output logic [AES_BLOCK_W-1:0] state_out
);

   logic [AES_BLOCK_W-1:0] sub_bytes;
   logic [AES_BLOCK_W-1:0] add_key;
   logic [AES_BLOCK_W-1:0] mixed;

   // InvShiftRows rotates row r right by r: out[r][c] = in[r][(c-r) mod 4].
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign sub_bytes[127-8*(4*c+r) -: 8] =
            inv_sbox(state_in[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
   end

   assign add_key = sub_bytes ^ rk;

   mix_cols #(
      .INVERSE (1'b1)
   ) u_mix (
      .din  (add_key),
      .dout (mixed)
   );

   assign state_out = last ? add_key : mixed;

endmodule
`default_nettype wire

// File: rtl/mix_cols.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mix_cols
// Purpose  : AES (Inv)MixColumns over a full 128-bit column-major state.
// Ports    : din  [127:0] - state in  ([127:96] is column 0)
//            dout [127:0] - state out
// Params   : INVERSE - 0: MixColumns (02 03 01 01), 1: InvMixColumns
//                      (0e 0b 0d 09)
// Revision : 1.0 - initial release
// ============================================================================
module mix_cols
   import aes_pkg::*;
#(
   parameter bit INVERSE = 1'b0
) (
   input  logic [127:0] din,
   output logic [127:0] dout
);

   // First matrix row; every other row is the same coefficients rotated.
   localparam logic [31:0] COEF = INVERSE ? 32'h0e0b0d09 : 32'h02030101;

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] col_in  [4];
      logic [7:0] col_out [4];

      for (genvar r = 0; r < 4; r++) begin : g_byte
         assign col_in[r]                  = din[127-8*(4*c+r) -: 8];
         assign dout[127-8*(4*c+r) -: 8]   = col_out[r];
      end

      always_comb begin
         for (int r = 0; r < 4; r++) begin
            col_out[r] = 8'h00;
            for (int k = 0; k < 4; k++) begin
               col_out[r] = col_out[r] ^ gf_mul(col_in[(r+k)%4], COEF[31-8*k -: 8]);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher
// Purpose  : Iterative AES inverse cipher, one round per clock. Decrypts one
//            128-bit block per transaction using round keys fetched from an
//            external key store through an index/data port.
// Ports    : clk          - clock, rising edge
//            rst_n        - asynchronous active-low reset
//            bus (slave)  - in_valid/in_ready/in_block, rk_idx/rk,
//                           out_valid/out_ready/out_block, busy
// Params   : NR - rounds (10/12/14 for AES-128/192/256)
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_cipher
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   aes_inv_cipher_if.slave  bus
);

   localparam logic [1:0] ST_IDLE  = INV_IDLE;
   localparam logic [1:0] ST_ROUND = INV_ROUND;
   localparam logic [1:0] ST_FINAL = INV_FINAL;
   localparam logic [1:0] ST_DONE  = INV_DONE;

   localparam logic [RK_IDX_W-1:0] NR_IDX   = RK_IDX_W'(NR);
   localparam logic [RK_IDX_W-1:0] NR_FIRST = RK_IDX_W'(NR - 1);

   if (!nr_legal(NR)) begin : g_nr_check
      $error("aes_inv_cipher: NR must be 10, 12 or 14");
   end

   logic [1:0]             state;
   logic [RK_IDX_W-1:0]    rnd;
   logic [AES_BLOCK_W-1:0] state_reg;
   logic [AES_BLOCK_W-1:0] out_block_reg;
   logic                   out_valid_reg;
   logic [AES_BLOCK_W-1:0] round_out;
   logic                   last;

   // One round instance serves both the full rounds and the final round.
   assign last = (state == ST_FINAL);

   aes_inv_round u_round (
      .state_in  (state_reg),
      .rk        (bus.rk),
      .last      (last),
      .state_out (round_out)
   );

   // Key index is a pure decode so the key store can answer in the same cycle.
   always_comb begin
      bus.rk_idx = NR_IDX;
      case (state)
         ST_ROUND:          bus.rk_idx = rnd;
         ST_FINAL, ST_DONE: bus.rk_idx = '0;
         default:           bus.rk_idx = NR_IDX;
      endcase
   end

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.busy      = (state != ST_IDLE);
   assign bus.out_valid = out_valid_reg;
   assign bus.out_block = out_block_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         rnd           <= '0;
         state_reg     <= '0;
         out_block_reg <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  state_reg <= bus.in_block ^ bus.rk;
                  rnd       <= NR_FIRST;
                  state     <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               state_reg <= round_out;
               if (rnd == 4'd1) state <= ST_FINAL;
               else             rnd   <= rnd - 4'd1;
            end
            ST_FINAL: begin
               out_block_reg <= round_out;
               out_valid_reg <= 1'b1;
               state         <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES inverse-cipher engine: decrypts one 128-bit block per transaction, one round per clock, using the inverse MixColumns path (`mix_cols` with `INVERSE=1`). It sits on the decrypt datapath between the input block FIFO and the output block sink. Round keys come from the external key store through an index/data lookup port. It is the decrypt counterpart of the encrypt round engine.

## Interface
- `NR`, default 10 — number of rounds: 10 for AES-128, 12 for AES-192, 14 for AES-256; any other value is a synthesis-time assertion failure.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — ciphertext block offered.
- `in_ready` out 1 — engine can accept a block; high only in IDLE.
- `in_block` in 128 — ciphertext. Byte ordering:
  - [127:120] is state byte s[0][0].
  - Column-major order.
  - [127:96] is column 0.
- `rk_idx` out 4 — round-key index requested from the key store.
- `rk` in 128 — round key for `rk_idx`, valid combinationally in the same cycle.
- `out_valid` out 1 — plaintext available.
- `out_ready` in 1 — sink accepts plaintext.
- `out_block` out 128 — plaintext, same byte ordering as `in_block`.
- `busy` out 1 — high in ROUND, FINAL and DONE.

## Operation
- **States:** IDLE, ROUND, FINAL, DONE. Round counter `rnd` is 4 bits.
- **IDLE:**
  - `rk_idx`=NR, `in_ready`=1.
  - On `in_valid && in_ready`: state_reg <= `in_block` ^ `rk`; `rnd` <= NR-1; go to ROUND.
- **ROUND:**
  - `rk_idx`=`rnd`.
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ `rk`).
  - If `rnd`==1, go to FINAL; else `rnd` <= `rnd`-1.
- **FINAL:**
  - `rk_idx`=0.
  - `out_block` <= InvSubBytes(InvShiftRows(state_reg)) ^ `rk`.
  - `out_valid` <= 1; go to DONE.
- **DONE:**
  - `rk_idx`=0.
  - Hold `out_valid` and `out_block` stable.
  - On `out_ready`: `out_valid` <= 0; go to IDLE.
- **Reset values:**
  - state IDLE, `rnd` 0, state_reg 0.
  - `out_block` 0, `out_valid` 0, `busy` 0.
  - `in_ready` 1 (decoded from IDLE).
  - `rk_idx` NR.
- **Boundary conditions:**
  - `in_valid` outside IDLE: ignored, not acknowledged; the block is not captured.
  - `out_ready` high when `out_valid`=0: no effect.
  - `out_ready` low in DONE: wait indefinitely, outputs frozen.
  - `rk` changing while in IDLE without a handshake: no state change.
  - `rst_n` low at any time, including mid-round: immediate abort to reset values, no `out_valid` pulse; the partial block is discarded.
  - `in_block` and `rk` are sampled only on the clock edges defined above.

## Timing
- Accept edge T0 performs the initial AddRoundKey.
- ROUND edges are T1..T(NR-1); the FINAL edge is T(NR).
- `out_valid` rises after edge T(NR): latency NR cycles from the accept edge (10 for AES-128).
- DONE-to-IDLE transition takes the edge where `out_ready` is high.
- The next accept is earliest one cycle later, so the minimum block period is NR+2 cycles.
- `rk_idx` is a pure decode of state and `rnd`, with no added latency. The key store must return `rk` combinationally in the same cycle.
- Critical path: state_reg → InvShiftRows → InvSubBytes → XOR → InvMixColumns → state_reg.

## Structure
- **Shared package `aes_pkg`:**
  - state enum `inv_fsm_e`.
  - constants `AES_BLOCK_W`=128, `RK_IDX_W`=4.
  - inverse S-box function `inv_sbox`.
  - legal-NR check function.
- **Sub-module `aes_inv_round` (combinational):**
  - InvShiftRows and InvSubBytes.
  - AddRoundKey with `rk`.
  - Optional inverse MixColumns via `mix_cols #(.INVERSE(1))`, bypassed when `last`=1.
  - One instance is shared by ROUND and FINAL.
- **Top level:** FSM, round counter, state register and output register only.

## Test plan
- **FIPS-197 C.1, NR=10:**
  - Stimulus: key store 000102..0f (rk[10]=13111d7fe3944a17f307a78b4d2b30c5); `in_block` 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: `out_block` 00112233445566778899aabbccddeeff; `out_valid` exactly 10 cycles after the accept edge.
- **Key index sequence:**
  - Same transaction: `rk_idx` reads 10,9,8,…,1,0 on consecutive cycles from T0.
  - `busy` is high from T1 until the cycle after the `out_ready` handshake.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles after `out_valid`.
  - `out_block` and `out_valid` stay stable and `in_ready`=0.
  - Pulse `in_valid` with ffff…ff: ignored. The next transaction decrypts a fresh block correctly.
- **Reset mid-operation:**
  - Assert `rst_n`=0 at `rk_idx`==5.
  - All outputs return to reset values asynchronously, with no `out_valid`.
  - After release, the C.1 vector still yields 00112233….
- **Zero key, NR=10:**
  - `in_block` 66e94bd4ef8a2c3b884cfa59ca342b2e → `out_block` 0.
  - Then 100 random blocks encrypted by the reference model: each decrypts to the original, and the block period is 12 cycles with `in_valid` and `out_ready` held high.
- **NR=14 instance, FIPS-197 C.3:**
  - Key 000102..1f; `in_block` 8ea2b7ca516745bfeafc49904b496089.
  - Response: `out_block` 00112233445566778899aabbccddeeff after 14 cycles.
